// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multi-cycle control FSM for the RV32I core.
// Sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB and
// drives datapath selects, write enables and the memory handshake.
// Optional build macro: ILLEGAL_TRAP_EN (unknown opcode -> HALT with trap=1;
// when undefined, unknown opcodes retire as a NOP and trap is tied 0).
module rv32i_mc_ctrl #(
    // Max cycles a memory request may wait before HALT (1..255)
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic [2:0]  ext_op,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        bus_err,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    // Instruction class held from DECODE until the next DECODE
    typedef enum logic [3:0] {
        C_NOP, C_OP, C_IMM, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
    } cls_t;

    localparam logic [2:0] EXT_I     = 3'b000;
    localparam logic [2:0] EXT_B     = 3'b001;
    localparam logic [2:0] EXT_J     = 3'b010;
    localparam logic [2:0] EXT_S     = 3'b011;
    localparam logic [2:0] EXT_U     = 3'b100;
    localparam logic [2:0] EXT_SHAMT = 3'b101;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_REL  = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [8:0] TO_LIM = 9'(MEM_TIMEOUT);

    state_t     state, state_n;
    cls_t       cls_d, cls_q;
    logic [2:0] ext_d, ext_q;
    logic       rd_nz_q;
    logic [7:0] to_cnt;
    logic       to_limit;
    logic       timeout_hit;
    logic       bus_err_q;

    // Only opcode, rd and funct3 steer control; the rest belongs to the datapath
    logic unused_inst;
    assign unused_inst = ^inst[31:15];

    // Opcode classification and immediate-format selection
    always_comb begin
        cls_d = C_ILL;
        ext_d = EXT_I;
        case (inst[6:0])
            7'b0010011: begin
                cls_d = C_IMM;
                // SLLI/SRLI/SRAI take a 5-bit shamt instead of a full imm
                if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101)
                    ext_d = EXT_SHAMT;
            end
            7'b0000011: cls_d = C_LOAD;
            7'b1100111: cls_d = C_JALR;
            7'b1100011: begin cls_d = C_BRANCH; ext_d = EXT_B; end
            7'b1101111: begin cls_d = C_JAL;    ext_d = EXT_J; end
            7'b0100011: begin cls_d = C_STORE;  ext_d = EXT_S; end
            7'b0110111: begin cls_d = C_LUI;    ext_d = EXT_U; end
            7'b0010111: begin cls_d = C_AUIPC;  ext_d = EXT_U; end
            7'b0110011: cls_d = C_OP;
            7'b0001111,
            7'b1110011: cls_d = C_NOP;
            default:    cls_d = C_ILL;
        endcase
    end

    // Latch decode results once per instruction so later states stay stable
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q   <= EXT_I;
            cls_q   <= C_NOP;
            rd_nz_q <= 1'b0;
        end else if (state == S_DECODE) begin
            ext_q   <= ext_d;
            cls_q   <= cls_d;
            rd_nz_q <= |inst[11:7];
        end
    end

    assign ext_op = ext_q;

    // The next unanswered request cycle would reach the limit
    assign to_limit = ({1'b0, to_cnt} + 9'd1) >= TO_LIM;

    // Next-state and control outputs; reset forces every enable low
    always_comb begin
        state_n     = state;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SEQ;
        alu_a_pc    = 1'b0;
        alu_b_imm   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_n = S_DECODE;
                end else if (to_limit) begin
                    timeout_hit = 1'b1;
                    state_n     = S_HALT;
                end
            end
            S_DECODE: begin
                state_n = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
                if (cls_d == C_ILL)
                    state_n = S_HALT;
`endif
            end
            S_EXEC: begin
                alu_b_imm = !(cls_q == C_OP || cls_q == C_BRANCH);
                alu_a_pc  = (cls_q == C_AUIPC || cls_q == C_JAL);
                case (cls_q)
                    C_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? PC_REL : PC_SEQ;
                        state_n = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_n = S_MEM;
                    // FENCE/SYSTEM and unrecognised opcodes retire as NOPs
                    C_NOP, C_ILL: begin
                        pc_we   = 1'b1;
                        state_n = S_FETCH;
                    end
                    default: state_n = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we   = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (to_limit) begin
                    timeout_hit = 1'b1;
                    state_n     = S_HALT;
                end
            end
            S_WB: begin
                reg_we  = rd_nz_q;
                pc_we   = 1'b1;
                state_n = S_FETCH;
                case (cls_q)
                    C_LOAD: wb_sel = WB_MEM;
                    C_JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_REL;
                    end
                    C_JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_JALR;
                    end
                    C_LUI:   wb_sel = WB_IMM;
                    default: wb_sel = WB_ALU;
                endcase
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
        // Reset aborts the instruction in flight: nothing may be written
        if (rst) begin
            state_n     = S_IDLE;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = PC_SEQ;
            alu_a_pc    = 1'b0;
            alu_b_imm   = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            reg_we      = 1'b0;
            wb_sel      = WB_ALU;
            timeout_hit = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Wait counter: restarts on entry to FETCH/MEM, counts unanswered request cycles
    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= '0;
        else if (state_n != state && (state_n == S_FETCH || state_n == S_MEM))
            to_cnt <= '0;
        else if (mem_req && !mem_ready)
            to_cnt <= to_cnt + 8'd1;
    end

    // Sticky bus error flag
    always_ff @(posedge clk) begin
        if (rst)
            bus_err_q <= 1'b0;
        else if (timeout_hit)
            bus_err_q <= 1'b1;
    end

    assign bus_err = bus_err_q;

`ifdef ILLEGAL_TRAP_EN
    logic trap_q;
    logic trap_set;

    assign trap_set = (state == S_DECODE) && (cls_d == C_ILL);

    // Sticky illegal-instruction flag
    always_ff @(posedge clk) begin
        if (rst)
            trap_q <= 1'b0;
        else if (trap_set)
            trap_q <= 1'b1;
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb_rv32i_mc_ctrl: per-cycle scoreboard bench for rv32i_mc_ctrl.
// Each queue entry carries the inputs for one cycle and the full expected
// output vector for that cycle; tasks push a scenario, then drain and compare.
module tb_rv32i_mc_ctrl;

    localparam int TO = 5;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        mem_ready;
    logic        br_taken;
    logic [2:0]  ext_op;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_a_pc;
    logic        alu_b_imm;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        bus_err;
    logic        trap;

    int checks = 0;
    int failures = 0;

    rv32i_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
        .br_taken(br_taken), .ext_op(ext_op), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel),
        .bus_err(bus_err), .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {ext_op, ir_we, pc_we, pc_sel, alu_a_pc, alu_b_imm,
                  mem_req, mem_we, reg_we, wb_sel, bus_err, trap};

    typedef struct packed {
        logic [31:0] ins;
        logic        rdy;
        logic        br;
        logic [15:0] exp;
    } ent_t;

    ent_t sbq[$];

    // Expected-vector builders, one per FSM state as the block is specified
    function automatic logic [15:0] ov(input logic [2:0] ext, input logic irwe,
        input logic pcwe, input logic [1:0] pcs, input logic apc, input logic bimm,
        input logic mreq, input logic mwe, input logic rwe, input logic [1:0] wbs,
        input logic be, input logic tr);
        return {ext, irwe, pcwe, pcs, apc, bimm, mreq, mwe, rwe, wbs, be, tr};
    endfunction
    function automatic logic [15:0] f_fetch(input logic [2:0] ext, input logic rdy);
        return ov(ext, rdy, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] f_zero(input logic [2:0] ext);
        return ov(ext, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] f_exec(input logic [2:0] ext, input logic pcwe,
        input logic [1:0] pcs, input logic apc, input logic bimm);
        return ov(ext, 0, pcwe, pcs, apc, bimm, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] f_mem(input logic [2:0] ext, input logic we,
        input logic pcwe);
        return ov(ext, 0, pcwe, 2'b00, 0, 0, 1, we, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] f_wb(input logic [2:0] ext, input logic rwe,
        input logic [1:0] wbs, input logic [1:0] pcs);
        return ov(ext, 0, 1, pcs, 0, 0, 0, 0, rwe, wbs, 0, 0);
    endfunction
    function automatic logic [15:0] f_halt(input logic [2:0] ext, input logic be,
        input logic tr);
        return ov(ext, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, be, tr);
    endfunction

    task automatic sb(input logic [31:0] i, input logic r, input logic b,
                      input logic [15:0] e);
        ent_t t;
        t.ins = i; t.rdy = r; t.br = b; t.exp = e;
        sbq.push_back(t);
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; inst = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (obs !== 16'h0) begin
            failures++;
            $display("FAIL reset_hold got=%h want=%h", obs, 16'h0);
        end
        rst = 1'b0; #1;
        checks++;
        if (obs !== 16'h0) begin
            failures++;
            $display("FAIL reset_idle got=%h want=%h", obs, 16'h0);
        end
    endtask

    task automatic test_alu;
        ent_t e;
        int n = 0;
        // ADDI x1,x0,5
        sb(32'h00500093, 1, 0, f_fetch(3'b000, 1));
        sb(32'h00500093, 0, 0, f_zero(3'b000));
        sb(32'h00500093, 0, 0, f_exec(3'b000, 0, 2'b00, 0, 1));
        sb(32'h00500093, 0, 0, f_wb(3'b000, 1, 2'b00, 2'b00));
        // ADD x3,x1,x2: ALU B from rs2
        sb(32'h002081B3, 1, 0, f_fetch(3'b000, 1));
        sb(32'h002081B3, 0, 0, f_zero(3'b000));
        sb(32'h002081B3, 0, 0, f_exec(3'b000, 0, 2'b00, 0, 0));
        sb(32'h002081B3, 0, 0, f_wb(3'b000, 1, 2'b00, 2'b00));
        // LUI x5: writes the immediate
        sb(32'h123452B7, 1, 0, f_fetch(3'b000, 1));
        sb(32'h123452B7, 0, 0, f_zero(3'b000));
        sb(32'h123452B7, 0, 0, f_exec(3'b100, 0, 2'b00, 0, 1));
        sb(32'h123452B7, 0, 0, f_wb(3'b100, 1, 2'b11, 2'b00));
        // AUIPC x6: ALU A = PC
        sb(32'h00000317, 1, 0, f_fetch(3'b100, 1));
        sb(32'h00000317, 0, 0, f_zero(3'b100));
        sb(32'h00000317, 0, 0, f_exec(3'b100, 0, 2'b00, 1, 1));
        sb(32'h00000317, 0, 0, f_wb(3'b100, 1, 2'b00, 2'b00));
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            inst = e.ins; mem_ready = e.rdy; br_taken = e.br;
            #1;
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("FAIL alu step%0d got=%h want=%h", n, obs, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_branch;
        ent_t e;
        int n = 0;
        // BEQ taken / not taken: 3 cycles, PC written in EXEC
        sb(32'h00000463, 1, 0, f_fetch(3'b100, 1));
        sb(32'h00000463, 0, 0, f_zero(3'b100));
        sb(32'h00000463, 0, 1, f_exec(3'b001, 1, 2'b01, 0, 0));
        sb(32'h00000463, 1, 0, f_fetch(3'b001, 1));
        sb(32'h00000463, 0, 0, f_zero(3'b001));
        sb(32'h00000463, 0, 0, f_exec(3'b001, 1, 2'b00, 0, 0));
        // FENCE and ECALL retire as NOPs
        sb(32'h0000000F, 1, 0, f_fetch(3'b001, 1));
        sb(32'h0000000F, 0, 1, f_zero(3'b001));
        sb(32'h0000000F, 0, 1, f_exec(3'b000, 1, 2'b00, 0, 1));
        sb(32'h00000073, 1, 0, f_fetch(3'b000, 1));
        sb(32'h00000073, 0, 0, f_zero(3'b000));
        sb(32'h00000073, 0, 0, f_exec(3'b000, 1, 2'b00, 0, 1));
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            inst = e.ins; mem_ready = e.rdy; br_taken = e.br;
            #1;
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("FAIL branch step%0d got=%h want=%h", n, obs, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_mem;
        ent_t e;
        int n = 0;
        // LW with 4 stalled MEM cycles
        sb(32'h0000A103, 1, 0, f_fetch(3'b000, 1));
        sb(32'h0000A103, 0, 0, f_zero(3'b000));
        sb(32'h0000A103, 0, 0, f_exec(3'b000, 0, 2'b00, 0, 1));
        for (int i = 0; i < 4; i++)
            sb(32'h0000A103, 0, 0, f_mem(3'b000, 0, 0));
        sb(32'h0000A103, 1, 0, f_mem(3'b000, 0, 0));
        sb(32'h0000A103, 0, 0, f_wb(3'b000, 1, 2'b01, 2'b00));
        // SW with 2 stalled FETCH cycles and 1 stalled MEM cycle
        sb(32'h0020A023, 0, 0, f_fetch(3'b000, 0));
        sb(32'h0020A023, 0, 0, f_fetch(3'b000, 0));
        sb(32'h0020A023, 1, 0, f_fetch(3'b000, 1));
        sb(32'h0020A023, 0, 0, f_zero(3'b000));
        sb(32'h0020A023, 0, 0, f_exec(3'b011, 0, 2'b00, 0, 1));
        sb(32'h0020A023, 0, 0, f_mem(3'b011, 1, 0));
        sb(32'h0020A023, 1, 0, f_mem(3'b011, 1, 1));
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            inst = e.ins; mem_ready = e.rdy; br_taken = e.br;
            #1;
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("FAIL mem step%0d got=%h want=%h", n, obs, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_jump;
        ent_t e;
        int n = 0;
        // JAL x0: no register write
        sb(32'h0000006F, 1, 0, f_fetch(3'b011, 1));
        sb(32'h0000006F, 0, 0, f_zero(3'b011));
        sb(32'h0000006F, 0, 0, f_exec(3'b010, 0, 2'b00, 1, 1));
        sb(32'h0000006F, 0, 0, f_wb(3'b010, 0, 2'b10, 2'b01));
        // JALR x1,0(x2)
        sb(32'h000100E7, 1, 0, f_fetch(3'b010, 1));
        sb(32'h000100E7, 0, 0, f_zero(3'b010));
        sb(32'h000100E7, 0, 0, f_exec(3'b000, 0, 2'b00, 0, 1));
        sb(32'h000100E7, 0, 0, f_wb(3'b000, 1, 2'b10, 2'b10));
        // SLLI / SRAI use the shamt format
        sb(32'h00209093, 1, 0, f_fetch(3'b000, 1));
        sb(32'h00209093, 0, 0, f_zero(3'b000));
        sb(32'h00209093, 0, 0, f_exec(3'b101, 0, 2'b00, 0, 1));
        sb(32'h00209093, 0, 0, f_wb(3'b101, 1, 2'b00, 2'b00));
        sb(32'h4020D093, 1, 0, f_fetch(3'b101, 1));
        sb(32'h4020D093, 0, 0, f_zero(3'b101));
        sb(32'h4020D093, 0, 0, f_exec(3'b101, 0, 2'b00, 0, 1));
        sb(32'h4020D093, 0, 0, f_wb(3'b101, 1, 2'b00, 2'b00));
        // ADDI x0: rd=0 suppresses reg_we
        sb(32'h00000013, 1, 0, f_fetch(3'b101, 1));
        sb(32'h00000013, 0, 0, f_zero(3'b101));
        sb(32'h00000013, 0, 0, f_exec(3'b000, 0, 2'b00, 0, 1));
        sb(32'h00000013, 0, 0, f_wb(3'b000, 0, 2'b00, 2'b00));
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            inst = e.ins; mem_ready = e.rdy; br_taken = e.br;
            #1;
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("FAIL jump step%0d got=%h want=%h", n, obs, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_timeout;
        ent_t e;
        int n = 0;
        // TO unanswered FETCH cycles -> HALT with sticky bus_err
        for (int i = 0; i < TO; i++)
            sb(32'h00500093, 0, 0, f_fetch(3'b000, 0));
        for (int i = 0; i < 3; i++)
            sb(32'h00500093, 1, 0, f_halt(3'b000, 1, 0));
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            inst = e.ins; mem_ready = e.rdy; br_taken = e.br;
            #1;
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("FAIL timeout step%0d got=%h want=%h", n, obs, e.exp);
            end
            n++;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (obs !== 16'h0) begin
            failures++;
            $display("FAIL timeout_clear got=%h want=%h", obs, 16'h0);
        end
        rst = 1'b0;
        // Ready arriving on the limit cycle wins: no error
        for (int i = 0; i < TO - 1; i++)
            sb(32'h00500093, 0, 0, f_fetch(3'b000, 0));
        sb(32'h00500093, 1, 0, f_fetch(3'b000, 1));
        sb(32'h00500093, 0, 0, f_zero(3'b000));
        sb(32'h00500093, 0, 0, f_exec(3'b000, 0, 2'b00, 0, 1));
        sb(32'h00500093, 0, 0, f_wb(3'b000, 1, 2'b00, 2'b00));
        n = 100;
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            inst = e.ins; mem_ready = e.rdy; br_taken = e.br;
            #1;
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("FAIL timeout step%0d got=%h want=%h", n, obs, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_illegal;
        ent_t e;
        int n = 0;
        sb(32'hFFFFFFFF, 1, 0, f_fetch(3'b000, 1));
        sb(32'hFFFFFFFF, 0, 0, f_zero(3'b000));
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++)
            sb(32'hFFFFFFFF, 1, 1, f_halt(3'b000, 0, 1));
`else
        sb(32'hFFFFFFFF, 0, 0, f_exec(3'b000, 1, 2'b00, 0, 1));
`endif
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            inst = e.ins; mem_ready = e.rdy; br_taken = e.br;
            #1;
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("FAIL illegal step%0d got=%h want=%h", n, obs, e.exp);
            end
            n++;
        end
`ifdef ILLEGAL_TRAP_EN
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (obs !== 16'h0) begin
            failures++;
            $display("FAIL trap_clear got=%h want=%h", obs, 16'h0);
        end
        rst = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_mem;
        ent_t e;
        int n = 0;
        sb(32'h0020A023, 1, 0, f_fetch(3'b000, 1));
        sb(32'h0020A023, 0, 0, f_zero(3'b000));
        sb(32'h0020A023, 0, 0, f_exec(3'b011, 0, 2'b00, 0, 1));
        sb(32'h0020A023, 0, 0, f_mem(3'b011, 1, 0));
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            inst = e.ins; mem_ready = e.rdy; br_taken = e.br;
            #1;
            checks++;
            if (obs !== e.exp) begin
                failures++;
                $display("FAIL rstmem step%0d got=%h want=%h", n, obs, e.exp);
            end
            n++;
        end
        rst = 1'b1; #1;
        checks++;
        if ({ir_we, pc_we, mem_req, mem_we, reg_we} !== 5'b0) begin
            failures++;
            $display("FAIL rstmem_abort got=%b want=%b",
                     {ir_we, pc_we, mem_req, mem_we, reg_we}, 5'b0);
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== 16'h0) begin
            failures++;
            $display("FAIL rstmem_idle got=%h want=%h", obs, 16'h0);
        end
        rst = 1'b0;
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++;
        if (obs !== f_fetch(3'b000, 1)) begin
            failures++;
            $display("FAIL rstmem_refetch got=%h want=%h", obs, f_fetch(3'b000, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_jump();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
